// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel switch conditioner: channel indices,
// output FSM states and the fixed issue priority.
package panel_pkg;

    localparam int unsigned NUM_CH = 5;

    typedef logic [2:0]        ch_idx_t;
    typedef logic [NUM_CH-1:0] ch_vec_t;

    localparam ch_idx_t CH_CLEAR = 3'd0;
    localparam ch_idx_t CH_RUN   = 3'd1;
    localparam ch_idx_t CH_HALT  = 3'd2;
    localparam ch_idx_t CH_STEPM = 3'd3;
    localparam ch_idx_t CH_STEPI = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        GAP
    } state_t;

    // Element 0 is the highest priority.
    localparam ch_idx_t [NUM_CH-1:0] PRIO_ORDER = {CH_STEPM, CH_STEPI, CH_RUN, CH_HALT, CH_CLEAR};

    function automatic ch_vec_t prio_pick(input ch_vec_t req);
        ch_vec_t grant;
        logic    found;
        grant = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!found && req[PRIO_ORDER[3'(i)]]) begin
                grant[PRIO_ORDER[3'(i)]] = 1'b1;
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/panel_switch_ctrl_if.sv
// Panel-switch pulse bundle between the switch conditioner and the CPU.
interface panel_switch_ctrl_if;

    logic sw_CLEAR;
    logic sw_RUN;
    logic sw_HALT;
    logic sw_STEPM;
    logic sw_STEPI;
    logic busy;

    modport master (output sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI, busy);
    modport slave  (input  sw_CLEAR, sw_RUN, sw_HALT, sw_STEPM, sw_STEPI, busy);

endinterface

// File: rtl/panel_debounce.sv
// One button channel: 2-flop synchroniser, stability counter, and a one-cycle
// press event on each rising edge of the debounced level.
module panel_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]       sync;
    logic             level;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync  <= '0;
            level <= 1'b0;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[0], raw};
            press <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            // Toggle on the sample that would bring the count to DEBOUNCE_CYCLES.
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt   <= '0;
                level <= ~level;
                press <= ~level;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/panel_switch_ctrl.sv
// Front-panel switch conditioner: debounces five buttons and issues one
// fixed-width, serialised pulse per press, with CLEAR pre-empting the rest.
module panel_switch_ctrl
    import panel_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned PULSE_CYCLES    = 3,
    parameter int unsigned CLEAR_CYCLES    = 25,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic                SYSCLK,
    input  logic                RESETN,
    input  logic                btn_CLEAR,
    input  logic                btn_RUN,
    input  logic                btn_HALT,
    input  logic                btn_STEPM,
    input  logic                btn_STEPI,
    panel_switch_ctrl_if.master sw
);

    localparam int unsigned MAX_A   = (CLEAR_CYCLES > PULSE_CYCLES) ? CLEAR_CYCLES : PULSE_CYCLES;
    localparam int unsigned MAX_LEN = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN + 1);
    localparam ch_vec_t     CLEAR_ONLY = ch_vec_t'(1) << CH_CLEAR;

    ch_vec_t          btn;
    ch_vec_t          press;
    ch_vec_t          pending;
    ch_vec_t          grant;
    ch_vec_t          out;
    state_t           state;
    logic [CNT_W-1:0] cnt;

    assign btn[CH_CLEAR] = btn_CLEAR;
    assign btn[CH_RUN]   = btn_RUN;
    assign btn[CH_HALT]  = btn_HALT;
    assign btn[CH_STEPM] = btn_STEPM;
    assign btn[CH_STEPI] = btn_STEPI;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        panel_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (SYSCLK),
            .rst_n(RESETN),
            .raw  (btn[g]),
            .press(press[g])
        );
    end

    always_comb grant = prio_pick(pending);

    always_ff @(posedge SYSCLK) begin
        if (!RESETN) begin
            state   <= IDLE;
            out     <= '0;
            pending <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pending) begin
                        state   <= PULSE;
                        out     <= grant;
                        cnt     <= grant[CH_CLEAR] ? CNT_W'(CLEAR_CYCLES) : CNT_W'(PULSE_CYCLES);
                        pending <= (pending & ~grant) | press;
                    end else begin
                        pending <= pending | press;
                    end
                end
                PULSE: begin
                    if (press[CH_CLEAR] && !out[CH_CLEAR]) begin
                        out     <= '0;
                        state   <= IDLE;
                        pending <= CLEAR_ONLY;
                    end else begin
                        // While CLEAR is on the wire only another CLEAR may queue.
                        pending <= out[CH_CLEAR] ? (pending | (press & CLEAR_ONLY)) : (pending | press);
                        if (cnt == CNT_W'(1)) begin
                            out   <= '0;
                            cnt   <= CNT_W'(GAP_CYCLES - 1);
                            state <= GAP;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (press[CH_CLEAR]) begin
                        state   <= IDLE;
                        pending <= CLEAR_ONLY;
                    end else begin
                        // The IDLE cycle that follows completes the idle gap.
                        pending <= pending | press;
                        if (cnt <= CNT_W'(1)) begin
                            state <= IDLE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sw.sw_CLEAR = out[CH_CLEAR];
    assign sw.sw_RUN   = out[CH_RUN];
    assign sw.sw_HALT  = out[CH_HALT];
    assign sw.sw_STEPM = out[CH_STEPM];
    assign sw.sw_STEPI = out[CH_STEPI];
    assign sw.busy     = (state != IDLE) | (|pending);

endmodule

// File: tb/tb_panel_switch_ctrl.sv
// Directed bench for panel_switch_ctrl with short debounce/pulse timing.
module tb_panel_switch_ctrl;

    localparam logic [4:0] M_CLEAR = 5'b00001;
    localparam logic [4:0] M_RUN   = 5'b00010;
    localparam logic [4:0] M_HALT  = 5'b00100;
    localparam logic [4:0] M_STEPM = 5'b01000;
    localparam logic [4:0] M_STEPI = 5'b10000;

    typedef struct {
        logic [4:0] btn;
        logic       rstn;
        logic [4:0] exp_sw;
        logic       exp_busy;
    } vec_t;

    logic SYSCLK;
    logic RESETN;
    logic btn_CLEAR, btn_RUN, btn_HALT, btn_STEPM, btn_STEPI;

    vec_t vecs [0:299];
    int   n_vec;
    int   n_tests;
    int   n_fail;

    panel_switch_ctrl_if sw_bus ();

    panel_switch_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .PULSE_CYCLES   (3),
        .CLEAR_CYCLES   (8),
        .GAP_CYCLES     (2)
    ) dut (
        .SYSCLK   (SYSCLK),
        .RESETN   (RESETN),
        .btn_CLEAR(btn_CLEAR),
        .btn_RUN  (btn_RUN),
        .btn_HALT (btn_HALT),
        .btn_STEPM(btn_STEPM),
        .btn_STEPI(btn_STEPI),
        .sw       (sw_bus.master)
    );

    initial SYSCLK = 1'b0;
    always #5 SYSCLK = ~SYSCLK;

    function automatic logic [4:0] sw_now();
        return {sw_bus.sw_STEPI, sw_bus.sw_STEPM, sw_bus.sw_HALT, sw_bus.sw_RUN, sw_bus.sw_CLEAR};
    endfunction

    task automatic apply(input logic [4:0] b, input logic r);
        btn_CLEAR = b[0];
        btn_RUN   = b[1];
        btn_HALT  = b[2];
        btn_STEPM = b[3];
        btn_STEPI = b[4];
        RESETN    = r;
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic check(input string tag, input int step, input logic [4:0] exp_sw, input logic exp_busy);
        n_tests++;
        if (sw_now() !== exp_sw) begin
            n_fail++;
            $display("FAIL %s step %0d sw: got %b expected %b", tag, step, sw_now(), exp_sw);
        end
        n_tests++;
        if (sw_bus.busy !== exp_busy) begin
            n_fail++;
            $display("FAIL %s step %0d busy: got %b expected %b", tag, step, sw_bus.busy, exp_busy);
        end
    endtask

    task automatic add_vec(input logic [4:0] b, input logic r, input logic [4:0] e, input logic eb);
        vecs[n_vec].btn      = b;
        vecs[n_vec].rstn     = r;
        vecs[n_vec].exp_sw   = e;
        vecs[n_vec].exp_busy = eb;
        n_vec++;
    endtask

    // Single press from idle: event at step 5, pending at 6, pulse from step 7.
    task automatic add_single(input logic [4:0] m, input int hold, input int total, input int width);
        for (int k = 0; k < total; k++) begin
            add_vec((k < hold) ? m : 5'b0, 1'b1,
                    (k >= 7 && k <= 6 + width) ? m : 5'b0,
                    (k >= 6 && k <= 7 + width));
        end
    endtask

    initial begin
        n_vec   = 0;
        n_tests = 0;
        n_fail  = 0;
        RESETN  = 1'b0;
        btn_CLEAR = 1'b0; btn_RUN = 1'b0; btn_HALT = 1'b0; btn_STEPM = 1'b0; btn_STEPI = 1'b0;

        for (int k = 0; k < 3; k++) add_vec(5'b0, 1'b0, 5'b0, 1'b0);
        add_single(M_RUN, 20, 30, 3);
        for (int k = 0; k < 30; k++)
            add_vec((k < 20 && ((k / 2) % 2) == 0) ? M_HALT : 5'b0, 1'b1, 5'b0, 1'b0);
        for (int k = 0; k < 30; k++)
            add_vec((k < 20) ? (M_HALT | M_STEPM) : 5'b0, 1'b1,
                    (k >= 7 && k <= 9) ? M_HALT : (k >= 12 && k <= 14) ? M_STEPM : 5'b0,
                    (k >= 6 && k <= 15));
        add_single(M_STEPI, 100, 110, 3);
        add_single(M_STEPI, 20, 30, 3);
        add_single(M_CLEAR, 20, 30, 8);

        for (int i = 0; i < n_vec; i++) begin
            apply(vecs[i].btn, vecs[i].rstn);
            check($sformatf("vec%0d", i), i, vecs[i].exp_sw, vecs[i].exp_busy);
        end

        // CLEAR event lands in the second RUN pulse cycle.
        for (int k = 0; k < 35; k++) begin
            logic [4:0] b;
            b = 5'b0;
            if (k < 20) b = b | M_RUN;
            if (k >= 3 && k < 20) b = b | M_CLEAR;
            apply(b, 1'b1);
            check("preempt", k,
                  (k == 7 || k == 8) ? M_RUN : (k >= 10 && k <= 17) ? M_CLEAR : 5'b0,
                  (k >= 6 && k <= 18));
        end

        // One-cycle reset during the STEPI pulse, button held throughout.
        for (int k = 0; k < 50; k++) begin
            apply((k < 40) ? M_STEPI : 5'b0, (k == 8) ? 1'b0 : 1'b1);
            check("reset_mid", k,
                  (k == 7 || (k >= 16 && k <= 18)) ? M_STEPI : 5'b0,
                  ((k >= 6 && k <= 7) || (k >= 15 && k <= 19)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
